// File: rtl/curve_periph_pkg.sv
// Shared register-map constants and FSM state type for the Curve25519 peripheral controller.
package curve_periph_pkg;

    localparam logic [7:0] SCALAR_BASE  = 8'h00;
    localparam logic [7:0] POINT_BASE   = 8'h20;
    localparam logic [7:0] RESULT_BASE  = 8'h40;
    localparam logic [7:0] CTRL_ADDR    = 8'h60;
    localparam logic [7:0] STATUS_ADDR  = 8'h61;
    localparam logic [7:0] VERSION_ADDR = 8'h62;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_INT_EN = 1;
    localparam int unsigned CTRL_CLR    = 2;

    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;
    localparam int unsigned STAT_ERR  = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN
    } state_t;

endpackage

// File: rtl/curve_periph_regs.sv
// Subaddress decode, operand forwarding, CTRL/STATUS storage and registered read mux.
module curve_periph_regs
    import curve_periph_pkg::*;
#(
    parameter logic [7:0] VERSION = 8'h01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] subaddr,
    input  logic [7:0] wr_data,
    input  logic       wr_pulse,
    output logic [7:0] rd_data,
    output logic       op_we,
    output logic       op_sel,
    output logic [4:0] op_addr,
    output logic [7:0] op_wdata,
    output logic [4:0] res_addr,
    input  logic [7:0] res_rdata,
    input  logic       busy,
    input  logic       launch,
    input  logic       finish_ok,
    input  logic       finish_timeout,
    output logic       start_req,
    output logic       done_int
);

    logic       done, err, int_en;
    logic       done_nxt, err_nxt;
    logic       operand_hit, result_hit, ctrl_wr, op_wr, clr, busy_err;
    logic [7:0] rd_mux;

    assign operand_hit = (subaddr[7:6] == SCALAR_BASE[7:6]);
    assign result_hit  = (subaddr[7:5] == RESULT_BASE[7:5]);
    assign ctrl_wr     = wr_pulse && (subaddr == CTRL_ADDR);
    assign op_wr       = wr_pulse && operand_hit;
    assign start_req   = ctrl_wr && wr_data[CTRL_START] && !busy;
    assign clr         = ctrl_wr && wr_data[CTRL_CLR];
    assign busy_err    = busy && (op_wr || (ctrl_wr && wr_data[CTRL_START]));
    assign done_int    = done && int_en;

    // The result buffer is read combinationally; holding its address at zero
    // during reset keeps every output quiet while reset is asserted.
    assign res_addr = reset ? '0 : subaddr[4:0];

    // Misuse while busy wins over the launch clear so it is never lost.
    always_comb begin
        done_nxt = done;
        err_nxt  = err;
        if (clr || launch) begin
            done_nxt = 1'b0;
            err_nxt  = 1'b0;
        end
        if (busy_err) begin
            err_nxt = 1'b1;
        end
        if (finish_ok) begin
            done_nxt = 1'b1;
        end
        if (finish_timeout) begin
            done_nxt = 1'b1;
            err_nxt  = 1'b1;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (result_hit) begin
            rd_mux = res_rdata;
        end else begin
            case (subaddr)
                CTRL_ADDR:    rd_mux[CTRL_INT_EN] = int_en;
                STATUS_ADDR: begin
                    rd_mux[STAT_BUSY] = busy;
                    rd_mux[STAT_DONE] = done;
                    rd_mux[STAT_ERR]  = err;
                end
                VERSION_ADDR: rd_mux = VERSION;
                default:      rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done     <= 1'b0;
            err      <= 1'b0;
            int_en   <= 1'b0;
            rd_data  <= '0;
            op_we    <= 1'b0;
            op_sel   <= 1'b0;
            op_addr  <= '0;
            op_wdata <= '0;
        end else begin
            done    <= done_nxt;
            err     <= err_nxt;
            rd_data <= rd_mux;
            op_we   <= 1'b0;
            if (ctrl_wr) begin
                int_en <= wr_data[CTRL_INT_EN];
            end
            if (op_wr && !busy) begin
                op_we    <= 1'b1;
                op_sel   <= subaddr[5];
                op_addr  <= subaddr[4:0];
                op_wdata <= wr_data;
            end
        end
    end

endmodule

// File: rtl/curve_periph_ctrl.sv
// Operation sequencer for the Curve25519 core: launch, run with timeout, completion/abort,
// with register decode delegated to curve_periph_regs.
module curve_periph_ctrl
    import curve_periph_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter logic [7:0]  VERSION        = 8'h01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] subaddr,
    input  logic [7:0] wr_data,
    input  logic       wr_pulse,
    output logic [7:0] rd_data,
    input  logic       rd_pulse,
    output logic       op_we,
    output logic       op_sel,
    output logic [4:0] op_addr,
    output logic [7:0] op_wdata,
    output logic [4:0] res_addr,
    input  logic [7:0] res_rdata,
    output logic       core_start,
    output logic       core_abort,
    input  logic       core_done,
    output logic       done_int
);

    localparam logic [31:0] TIMEOUT_LIM = TIMEOUT_CYCLES;

    state_t      state, state_nxt;
    logic [31:0] cnt, cnt_inc;
    logic        timeout_hit, start_req, finish_ok, finish_timeout;
    logic        unused_rd_pulse;

    assign unused_rd_pulse = rd_pulse;

    assign cnt_inc     = (cnt == '1) ? cnt : cnt + 32'd1;
    assign timeout_hit = (TIMEOUT_LIM != '0) && (cnt_inc >= TIMEOUT_LIM);

    curve_periph_regs #(
        .VERSION(VERSION)
    ) u_regs (
        .clk            (clk),
        .reset          (reset),
        .subaddr        (subaddr),
        .wr_data        (wr_data),
        .wr_pulse       (wr_pulse),
        .rd_data        (rd_data),
        .op_we          (op_we),
        .op_sel         (op_sel),
        .op_addr        (op_addr),
        .op_wdata       (op_wdata),
        .res_addr       (res_addr),
        .res_rdata      (res_rdata),
        .busy           (state != ST_IDLE),
        .launch         (state == ST_LAUNCH),
        .finish_ok      (finish_ok),
        .finish_timeout (finish_timeout),
        .start_req      (start_req),
        .done_int       (done_int)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_LAUNCH) begin
                cnt <= '0;
            end else if (state == ST_RUN) begin
                cnt <= cnt_inc;
            end
        end
    end

    // Completion in the same cycle as the timeout takes priority over the abort.
    always_comb begin
        state_nxt      = state;
        core_start     = 1'b0;
        core_abort     = 1'b0;
        finish_ok      = 1'b0;
        finish_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                core_start = 1'b1;
                state_nxt  = ST_RUN;
            end
            ST_RUN: begin
                if (core_done) begin
                    finish_ok = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (timeout_hit) begin
                    core_abort     = 1'b1;
                    finish_timeout = 1'b1;
                    state_nxt      = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
